riscv_mem_bridge: RTL and testbench
===================================

Name: riscv_mem_bridge

Overview:
- Sits directly downstream of the single-cycle RV32I core, on its data-memory port (address, store data, byte enables, read strobe).
- Converts each core access into one registered valid/ready transaction on a shared data bus that may insert wait states.
- Stalls the core until the transaction completes, then returns read data.
- Decodes the target region as RAM, VRAM or I/O.

Parameters:
- TIMEOUT, 16: bus wait cycles before abort; only used with the optional feature; range 1..255.
- RAM_TAG, 3'b000: value of cpu_addr[31:29] that selects RAM.
- VRAM_TAG, 3'b001: value of cpu_addr[31:29] that selects VRAM.
- IO_TAG, 3'b101: value of cpu_addr[31:29] that selects I/O.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- clr  in  1  reset, synchronous, active-high.
- cpu_addr  in  32  core memory/I/O byte address.
- cpu_wdata  in  32  core store data, already lane-aligned.
- cpu_write  in  4  core byte write enables; nonzero means store.
- cpu_read  in  1  core load strobe.
- cpu_rdata  out  32  load data returned to the core.
- cpu_stall  out  1  holds the core PC and inputs while high.
- bus_valid  out  1  transaction request.
- bus_ready  in  1  target accepts/completes the transaction this cycle.
- bus_addr  out  32  word address, bits [1:0] forced to 0.
- bus_wdata  out  32  store data.
- bus_be  out  4  byte enables; 4'hF for reads.
- bus_we  out  1  1 = write, 0 = read.
- bus_sel  out  2  target: 0 RAM, 1 VRAM, 2 I/O.
- bus_rdata  in  32  read data, valid when bus_valid and bus_ready are both high.
- bus_err  out  1  sticky timeout flag.

Behaviour:
- Reset values (clr high at an edge): state IDLE; bus_valid 0; bus_we 0; bus_be 0; bus_addr 0; bus_wdata 0; bus_sel 0; cpu_rdata 0; bus_err 0; timeout counter 0.
- Reset is synchronous: clr overrides everything, including a bus_ready arriving in the same cycle. A transaction in flight is dropped without capture; the target must tolerate bus_valid falling.
- Request present: req = cpu_read OR (cpu_write != 0).
- cpu_stall = req AND (state != RESP). This is combinational from the registered state.
- State IDLE:
  - If req and the region is mapped: latch addr, wdata, be, we and sel into the bus registers, set bus_valid, go to REQ.
  - If req and the region is unmapped: go to RESP with cpu_rdata = 0; no bus activity.
- State REQ:
  - Hold all bus outputs stable.
  - When bus_ready is high: capture bus_rdata into cpu_rdata (reads only; writes leave cpu_rdata at 0), clear bus_valid, go to RESP.
- State RESP: cpu_stall is low, so the core retires the access at this edge. Go to IDLE unconditionally. RESP never launches a new transaction, so a held address cannot be issued twice.
- Latency:
  - Zero-wait target: core stalled 2 cycles, access retires on the 3rd cycle.
  - Each target wait cycle adds 1 stall cycle.
- Store and load asserted together: the write wins, bus_we = 1, cpu_rdata = 0.
- Region decode:
  - Only cpu_addr[31:29] is compared against the tags.
  - Any tag other than RAM_TAG, VRAM_TAG or IO_TAG is unmapped.
- No request in IDLE: stay in IDLE with bus_valid low.

Optional Feature:
- Macro: MEM_BRIDGE_TIMEOUT_EN.
- Defined:
  - An 8-bit counter increments each REQ cycle with bus_ready low.
  - When the count reaches TIMEOUT-1 with bus_ready still low: drop bus_valid, set cpu_rdata = 32'hFFFF_FFFF, set bus_err, go to RESP.
  - bus_err clears only on clr.
  - The counter zeroes on entry to REQ.
- Undefined: no counter; REQ waits indefinitely; the bus_err port remains and is tied to 0.

Decomposition:
- Package riscv_mem_pkg holds:
  - state encoding IDLE/REQ/RESP;
  - bus_sel codes SEL_RAM/SEL_VRAM/SEL_IO;
  - default region tags;
  - constant TIMEOUT_DATA = 32'hFFFF_FFFF.
- Sub-module riscv_addr_decode is combinational: cpu_addr[31:29] -> sel[1:0] plus a mapped flag. It is reused later by the instruction-fetch side.

Test Plan:
- Zero-wait read: cpu_read=1, cpu_addr=32'h0000_0104, bus_ready high in first REQ cycle, bus_rdata=32'hCAFE_0001 -> bus_addr=32'h0000_0104, bus_be=4'hF, stall high 2 cycles, cpu_rdata=32'hCAFE_0001 in RESP.
- Byte store with 3 wait cycles: cpu_write=4'b0100, cpu_addr=32'h2000_0002, cpu_wdata=32'h00AB_0000 -> bus_sel=1, bus_addr=32'h2000_0000, bus_be=4'b0100, bus_we=1, outputs stable 4 REQ cycles, stall 5 cycles total.
- Unmapped load: cpu_addr=32'hE000_0000 -> bus_valid never asserted, 1 stall cycle, cpu_rdata=0.
- Back-to-back: address held through RESP -> exactly one bus transaction; new address in the cycle after RESP -> second transaction starts from IDLE.
- Reset mid-REQ: clr pulsed for 1 cycle during a wait state -> next cycle bus_valid=0, state IDLE, cpu_rdata=0, no capture even though bus_ready=1 in the clr cycle.
- Timeout (macro defined, TIMEOUT=16): bus_ready held low -> abort after 16 REQ cycles, cpu_rdata=32'hFFFF_FFFF, bus_err=1 until clr.

Source files
------------

// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: shared state, target-select and region-tag encodings for the data-memory bridge
package riscv_mem_pkg;
  typedef enum logic [1:0] {IDLE, REQ, RESP} state_e;
  localparam logic [1:0] SEL_RAM = 2'd0;
  localparam logic [1:0] SEL_VRAM = 2'd1;
  localparam logic [1:0] SEL_IO = 2'd2;
  localparam logic [2:0] DEF_RAM_TAG = 3'b000;
  localparam logic [2:0] DEF_VRAM_TAG = 3'b001;
  localparam logic [2:0] DEF_IO_TAG = 3'b101;
  localparam logic [31:0] TIMEOUT_DATA = 32'hFFFF_FFFF;
endpackage

// File: rtl/riscv_addr_decode.sv
// riscv_addr_decode: maps the top three address bits to a bus target and a mapped flag
module riscv_addr_decode
  import riscv_mem_pkg::*;
#(
  parameter logic [2:0] RAM_TAG = DEF_RAM_TAG,
  parameter logic [2:0] VRAM_TAG = DEF_VRAM_TAG,
  parameter logic [2:0] IO_TAG = DEF_IO_TAG
) (
  input  logic [2:0] tag_i,
  output logic [1:0] sel_o,
  output logic       mapped_o
);
  // pure tag compare; unmapped tags still yield SEL_RAM but are flagged
  always_comb begin
    sel_o = tag_i == VRAM_TAG ? SEL_VRAM : tag_i == IO_TAG ? SEL_IO : SEL_RAM;
    mapped_o = tag_i == RAM_TAG || tag_i == VRAM_TAG || tag_i == IO_TAG;
  end
endmodule

// File: rtl/riscv_mem_bridge.sv
// riscv_mem_bridge: turns core data accesses into registered valid/ready bus transactions; MEM_BRIDGE_TIMEOUT_EN adds a wait-state abort
module riscv_mem_bridge
  import riscv_mem_pkg::*;
#(
  parameter int unsigned TIMEOUT = 16,
  parameter logic [2:0] RAM_TAG = DEF_RAM_TAG,
  parameter logic [2:0] VRAM_TAG = DEF_VRAM_TAG,
  parameter logic [2:0] IO_TAG = DEF_IO_TAG
) (
  input  logic        clk,
  input  logic        clr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  input  logic [3:0]  cpu_write,
  input  logic        cpu_read,
  output logic [31:0] cpu_rdata,
  output logic        cpu_stall,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic        bus_we,
  output logic [1:0]  bus_sel,
  input  logic [31:0] bus_rdata,
  output logic        bus_err
);
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("riscv_mem_bridge: TIMEOUT must be 1..255");
  end
  state_e state_q;
  logic [31:0] cpu_rdata_q, bus_addr_q, bus_wdata_q;
  logic [3:0] bus_be_q;
  logic [1:0] bus_sel_q, sel;
  logic bus_valid_q, bus_we_q, mapped, req, wr;
`ifdef MEM_BRIDGE_TIMEOUT_EN
  logic [7:0] cnt_q;
  logic err_q;
  assign bus_err = err_q;
`else
  assign bus_err = 1'b0;
`endif
  riscv_addr_decode #(
    .RAM_TAG(RAM_TAG),
    .VRAM_TAG(VRAM_TAG),
    .IO_TAG(IO_TAG)
  ) u_dec (
    .tag_i(cpu_addr[31:29]),
    .sel_o(sel),
    .mapped_o(mapped)
  );
  // request detect and stall, released only while the access retires in RESP
  always_comb begin
    wr = |cpu_write;
    req = cpu_read || wr;
    cpu_stall = req && state_q != RESP;
  end
  assign cpu_rdata = cpu_rdata_q;
  assign bus_valid = bus_valid_q;
  assign bus_addr = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_be = bus_be_q;
  assign bus_we = bus_we_q;
  assign bus_sel = bus_sel_q;
  // bridge FSM: IDLE launches, REQ waits on the target, RESP lets the core retire
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      bus_valid_q <= 1'b0;
      bus_we_q <= 1'b0;
      bus_be_q <= '0;
      bus_addr_q <= '0;
      bus_wdata_q <= '0;
      bus_sel_q <= SEL_RAM;
      cpu_rdata_q <= '0;
`ifdef MEM_BRIDGE_TIMEOUT_EN
      cnt_q <= '0;
      err_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: if (req) begin
          cpu_rdata_q <= '0;
          state_q <= mapped ? REQ : RESP;
          if (mapped) begin
            bus_valid_q <= 1'b1;
            bus_addr_q <= cpu_addr & ~32'h3;
            bus_wdata_q <= cpu_wdata;
            bus_be_q <= wr ? cpu_write : 4'hF;
            bus_we_q <= wr;
            bus_sel_q <= sel;
`ifdef MEM_BRIDGE_TIMEOUT_EN
            cnt_q <= '0;
`endif
          end
        end
        REQ: if (bus_ready) begin
          cpu_rdata_q <= bus_we_q ? '0 : bus_rdata;
          bus_valid_q <= 1'b0;
          state_q <= RESP;
        end
`ifdef MEM_BRIDGE_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          cpu_rdata_q <= TIMEOUT_DATA;
          bus_valid_q <= 1'b0;
          err_q <= 1'b1;
          state_q <= RESP;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_riscv_mem_bridge.sv
// tb_riscv_mem_bridge: vector table plus hand sequences for held requests, mid-transfer reset and timeout
module tb_riscv_mem_bridge;
  logic clk = 1'b0, clr = 1'b1;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0, cpu_rdata, bus_addr, bus_wdata, bus_rdata = '0;
  logic [3:0] cpu_write = '0, bus_be;
  logic cpu_read = 1'b0, cpu_stall, bus_valid, bus_ready = 1'b0, bus_we, bus_err;
  logic [1:0] bus_sel;
  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        we;
    logic [1:0]  sel;
  } bus_t;
  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  write;
    logic        read;
    int          waits;
    logic [31:0] brdata;
    bit          mapped;
    bus_t        b;
    logic [31:0] rdata;
  } vec_t;
  bus_t sbq[$];
  vec_t vt[10];
  vec_t v;
  int errors = 0, checks = 0;

  riscv_mem_bridge dut (
    .clk(clk), .clr(clr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata), .cpu_write(cpu_write),
    .cpu_read(cpu_read), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_be(bus_be),
    .bus_we(bus_we), .bus_sel(bus_sel), .bus_rdata(bus_rdata), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // drive one access from IDLE, act as the target, and retire it; hold keeps the request up afterwards
  task automatic run_access(input vec_t x, input bit hold);
    int stalls = 0, reqs = 0;
    bit seen = 0, done = 0;
    bus_t eb = '0, gb;
    cpu_addr = x.addr; cpu_wdata = x.wdata; cpu_write = x.write; cpu_read = x.read;
    bus_rdata = x.brdata; bus_ready = 1'b0;
    if (x.mapped) sbq.push_back(x.b);
    for (int n = 0; n < 64 && !done; n++) begin
      #1;
      if (!cpu_stall) begin
        done = 1;
      end else begin
        stalls++;
        if (bus_valid) begin
          if (!seen) begin
            seen = 1;
            if (sbq.size() == 0) chk("sb_underflow", sbq.size(), 1);
            else eb = sbq.pop_front();
          end
          reqs++;
          gb = '{bus_addr, bus_wdata, bus_be, bus_we, bus_sel};
          chk("bus_txn", gb, eb);
          bus_ready = reqs > x.waits;
        end
        @(posedge clk); #1;
      end
    end
    if (!done) chk("retire_bound", cpu_stall, 1'b0);
    chk("stall_cycles", stalls, x.mapped ? 2 + x.waits : 1);
    chk("req_cycles", reqs, x.mapped ? x.waits + 1 : 0);
    chk("cpu_rdata", cpu_rdata, x.rdata);
    chk("resp_valid", bus_valid, 1'b0);
    chk("sb_drained", sbq.size(), 0);
    chk("bus_err", bus_err, 1'b0);
    bus_ready = 1'b0;
    if (!hold) begin
      cpu_read = 1'b0; cpu_write = '0;
    end
    @(posedge clk); #2;
    chk("idle_valid", bus_valid, 1'b0);
    chk("idle_stall", cpu_stall, hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    vt[0] = '{32'h0000_0104, 32'h0, 4'h0, 1'b1, 0, 32'hCAFE_0001, 1, '{32'h0000_0104, 32'h0, 4'hF, 1'b0, 2'd0}, 32'hCAFE_0001};
    vt[1] = '{32'h2000_0002, 32'h00AB_0000, 4'b0100, 1'b0, 3, 32'h9999_9999, 1, '{32'h2000_0000, 32'h00AB_0000, 4'b0100, 1'b1, 2'd1}, 32'h0};
    vt[2] = '{32'hE000_0000, 32'h0, 4'h0, 1'b1, 0, 32'h1111_1111, 0, '{32'h0, 32'h0, 4'h0, 1'b0, 2'd0}, 32'h0};
    vt[3] = '{32'hA000_0013, 32'h5A5A_5A5A, 4'h0, 1'b1, 1, 32'h1234_5678, 1, '{32'hA000_0010, 32'h5A5A_5A5A, 4'hF, 1'b0, 2'd2}, 32'h1234_5678};
    vt[4] = '{32'h0000_0040, 32'h0000_BEEF, 4'b0011, 1'b1, 2, 32'hDEAD_DEAD, 1, '{32'h0000_0040, 32'h0000_BEEF, 4'b0011, 1'b1, 2'd0}, 32'h0};
    vt[5] = '{32'h3FFF_FFFC, 32'h1122_3344, 4'hF, 1'b0, 0, 32'h2222_2222, 1, '{32'h3FFF_FFFC, 32'h1122_3344, 4'hF, 1'b1, 2'd1}, 32'h0};
    vt[6] = '{32'h4000_0000, 32'h0000_00FF, 4'b0001, 1'b0, 0, 32'h0, 0, '{32'h0, 32'h0, 4'h0, 1'b0, 2'd0}, 32'h0};
    vt[7] = '{32'h1FFF_FFFF, 32'h0, 4'h0, 1'b1, 0, 32'h0BAD_F00D, 1, '{32'h1FFF_FFFC, 32'h0, 4'hF, 1'b0, 2'd0}, 32'h0BAD_F00D};
    vt[8] = '{32'hFFFF_FFF0, 32'h0, 4'h0, 1'b1, 0, 32'h3333_3333, 0, '{32'h0, 32'h0, 4'h0, 1'b0, 2'd0}, 32'h0};
    vt[9] = '{32'hBFFF_FFFE, 32'hC0DE_0000, 4'b1100, 1'b0, 4, 32'h4444_4444, 1, '{32'hBFFF_FFFC, 32'hC0DE_0000, 4'b1100, 1'b1, 2'd2}, 32'h0};
    repeat (2) @(posedge clk);
    #1 clr = 1'b0;
    #1;
    chk("rst_valid", bus_valid, 1'b0);
    chk("rst_bus", {bus_addr, bus_wdata, bus_be, bus_we, bus_sel}, '0);
    chk("rst_rdata", cpu_rdata, 32'h0);
    chk("rst_err", bus_err, 1'b0);
    chk("rst_stall", cpu_stall, 1'b0);
    @(posedge clk); #1;
    for (int i = 0; i < 10; i++) run_access(vt[i], 1'b0);
    v = '{32'h0000_0200, 32'h0, 4'h0, 1'b1, 0, 32'hAAAA_0001, 1, '{32'h0000_0200, 32'h0, 4'hF, 1'b0, 2'd0}, 32'hAAAA_0001};
    run_access(v, 1'b1);
    v = '{32'h0000_0300, 32'h0, 4'h0, 1'b1, 1, 32'h0000_0ABC, 1, '{32'h0000_0300, 32'h0, 4'hF, 1'b0, 2'd0}, 32'h0000_0ABC};
    run_access(v, 1'b0);
    cpu_addr = 32'hA000_0104; cpu_read = 1'b1; cpu_write = '0; cpu_wdata = 32'h0;
    bus_ready = 1'b0; bus_rdata = 32'h5555_5555;
    @(posedge clk); #2;
    chk("mid_valid", bus_valid, 1'b1);
    @(posedge clk); #1;
    clr = 1'b1; bus_ready = 1'b1;
    @(posedge clk); #1;
    clr = 1'b0; bus_ready = 1'b0;
    #1;
    chk("mid_rst_valid", bus_valid, 1'b0);
    chk("mid_rst_bus", {bus_addr, bus_wdata, bus_be, bus_we, bus_sel}, '0);
    chk("mid_rst_rdata", cpu_rdata, 32'h0);
    chk("mid_rst_stall", cpu_stall, 1'b1);
    @(posedge clk); #2;
    chk("relaunch_valid", bus_valid, 1'b1);
    chk("relaunch_addr", bus_addr, 32'hA000_0104);
    bus_ready = 1'b1; bus_rdata = 32'h0000_0ACE;
    @(posedge clk); #2;
    chk("relaunch_stall", cpu_stall, 1'b0);
    chk("relaunch_rdata", cpu_rdata, 32'h0000_0ACE);
    bus_ready = 1'b0; cpu_read = 1'b0;
    @(posedge clk); #1;
`ifdef MEM_BRIDGE_TIMEOUT_EN
    begin
      int stalls = 0, reqs = 0;
      bit done = 0;
      cpu_addr = 32'h0000_0010; cpu_read = 1'b1; bus_ready = 1'b0;
      for (int n = 0; n < 64 && !done; n++) begin
        #1;
        if (!cpu_stall) done = 1;
        else begin
          stalls++;
          if (bus_valid) reqs++;
          @(posedge clk); #1;
        end
      end
      chk("to_stall_cycles", stalls, 17);
      chk("to_req_cycles", reqs, 16);
      chk("to_rdata", cpu_rdata, 32'hFFFF_FFFF);
      chk("to_err", bus_err, 1'b1);
      chk("to_valid", bus_valid, 1'b0);
      cpu_read = 1'b0;
      repeat (3) @(posedge clk);
      #2 chk("to_err_sticky", bus_err, 1'b1);
      clr = 1'b1;
      @(posedge clk); #1 clr = 1'b0;
      #1 chk("to_err_clr", bus_err, 1'b0);
    end
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
